// File: rtl/i2s_serializer.sv
// ============================================================================
// i2s_serializer
//
// Purpose
//   Serialises the core's parallel left/right DAC words as a standard I2S
//   stream (SCLK / LRCK / SDATA) for the board codec. The bit clock runs at
//   64*fs. A fractional phase accumulator derives it from clk, so no PLL is
//   needed. Both channels are latched together once per frame, and the latch
//   is reported with a one-clk strobe.
//
// Parameters
//   SYS_CLK_HZ : frequency of clk in Hz
//   SAMPLE_HZ  : output frame rate fs; 128*SAMPLE_HZ must not exceed SYS_CLK_HZ
//   DATA_W     : sample width, at most 32
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-high reset (released synchronously)
//   left_chan     in   left sample, two's complement, used only at frame latch
//   right_chan    in   right sample, two's complement, used only at frame latch
//   mute          in   1 = latch zeros instead of the inputs at next frame latch
//   sample_strobe out  one-clk pulse on the clk where both channels are latched
//   sclk          out  I2S bit clock
//   lrclk         out  I2S word select, 0 = left, 1 = right
//   sdata         out  I2S serial data, MSB first
//
// Frame layout (64 sclk periods, one slot per period)
//   slots  0..31 : left word MSB first, then zero padding
//   slots 32..63 : right word MSB first, then zero padding
//   lrclk is high for slots 31..62. It leads each word's MSB by one sclk.
//   All outputs change only on the clk where sclk falls. They are therefore
//   stable across every rising edge, where the codec samples them.
// ============================================================================
module i2s_serializer #(
    parameter int SYS_CLK_HZ = 14_000_000,
    parameter int SAMPLE_HZ  = 48_000,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_chan,
    input  logic [DATA_W-1:0] right_chan,
    input  logic              mute,
    output logic              sample_strobe,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata
);

    // Accumulator step and modulus. Both are widened to 33 bits so that the
    // sum of a 32-bit accumulator and the step cannot overflow before the
    // comparison.
    localparam logic [32:0] ACC_INC = 33'(128 * SAMPLE_HZ);
    localparam logic [32:0] ACC_MOD = 33'(SYS_CLK_HZ);

    // ------------------------------------------------------------------------
    // Reset synchroniser. Assertion reaches every register immediately
    // through the async set. Release is delayed to a clk edge, so no state
    // register leaves reset near an active edge.
    // ------------------------------------------------------------------------
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [31:0]       r_acc;
    logic [5:0]        r_slot;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;
    logic              r_sclk;
    logic              r_lrclk;
    logic              r_sdata;
    logic              r_strobe;

    // ------------------------------------------------------------------------
    // Combinational next-state helpers
    // ------------------------------------------------------------------------
    logic [32:0]       w_acc_sum;
    logic              w_tick;
    logic [31:0]       w_acc_next;
    logic [5:0]        w_slot_next;
    logic              w_frame_start;
    logic [DATA_W-1:0] w_left_next;
    logic [DATA_W-1:0] w_right_next;
    logic              w_fall;

    // Serial bit for a given slot. Within each 32-slot half, the first DATA_W
    // slots carry the word MSB first and the remaining slots are zero.
    // A left shift is used instead of a computed bit index to keep every
    // index width exact.
    function automatic logic slot_bit(
        input logic [5:0]        slot,
        input logic [DATA_W-1:0] left_w,
        input logic [DATA_W-1:0] right_w
    );
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] shifted;
        word    = slot[5] ? right_w : left_w;
        shifted = word << slot[4:0];
        if (int'(slot[4:0]) < DATA_W) begin
            return shifted[DATA_W-1];
        end
        return 1'b0;
    endfunction

    // Word select for a given slot. It is high from the slot before the right
    // MSB through the slot before the next left MSB.
    function automatic logic slot_lr(input logic [5:0] slot);
        return (slot >= 6'd31) && (slot <= 6'd62);
    endfunction

    always_comb begin
        w_acc_sum  = {1'b0, r_acc} + ACC_INC;
        w_tick     = (w_acc_sum >= ACC_MOD);
        w_acc_next = w_tick ? 32'(w_acc_sum - ACC_MOD) : w_acc_sum[31:0];
    end

    // A falling edge happens on a tick while sclk is high. Slot 63 wraps to 0
    // through the natural 6-bit overflow.
    assign w_fall        = w_tick && r_sclk;
    assign w_slot_next   = r_slot + 6'd1;
    assign w_frame_start = (w_slot_next == 6'd0);

    // The frame's first bit must come from the value being latched on this
    // same clk (zero latency). The serial-bit function is therefore fed the
    // post-latch words, not the shadow registers.
    assign w_left_next  = w_frame_start ? (mute ? '0 : left_chan)  : r_left;
    assign w_right_next = w_frame_start ? (mute ? '0 : right_chan) : r_right;

    // ------------------------------------------------------------------------
    // Bit-clock generator, slot counter, latch and serial outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_acc    <= '0;
            r_slot   <= 6'd63;
            r_left   <= '0;
            r_right  <= '0;
            r_sclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_sdata  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_acc    <= w_acc_next;
            r_strobe <= 1'b0;
            if (w_tick) begin
                r_sclk <= ~r_sclk;
            end
            // The rising edge only toggles sclk. Everything else moves on the
            // falling edge, so the codec always samples settled data.
            if (w_fall) begin
                r_slot   <= w_slot_next;
                r_left   <= w_left_next;
                r_right  <= w_right_next;
                r_strobe <= w_frame_start;
                r_lrclk  <= slot_lr(w_slot_next);
                r_sdata  <= slot_bit(w_slot_next, w_left_next, w_right_next);
            end
        end
    end

    assign sample_strobe = r_strobe;
    assign sclk          = r_sclk;
    assign lrclk         = r_lrclk;
    assign sdata         = r_sdata;

endmodule

// File: tb/tb_i2s_serializer.sv
// ============================================================================
// tb_i2s_serializer
//
// Two instances share clk, reset and the data inputs:
//   u_dut  : default clocking (14 MHz / 48 kHz), fractional sclk
//   u_fast : 1.28 MHz / 10 kHz, sclk toggles every clk
// The reference model works at frame level. Each observed strobe opens an
// expected 64-bit frame {L, 16'h0, R, 16'h0}, built from the inputs present
// on the latch clk. The serial stream is then decoded on sclk rising edges
// and compared word by word.
// ============================================================================
module tb_i2s_serializer;

    logic        clk;
    logic        reset;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        mute;

    logic sample_strobe, sclk, lrclk, sdata;
    logic f_strobe, f_sclk, f_lrclk, f_sdata;

    i2s_serializer #(
        .SYS_CLK_HZ(14_000_000), .SAMPLE_HZ(48_000), .DATA_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .left_chan(left_chan), .right_chan(right_chan),
        .mute(mute), .sample_strobe(sample_strobe), .sclk(sclk), .lrclk(lrclk),
        .sdata(sdata)
    );

    i2s_serializer #(
        .SYS_CLK_HZ(1_280_000), .SAMPLE_HZ(10_000), .DATA_W(16)
    ) u_fast (
        .clk(clk), .reset(reset), .left_chan(left_chan), .right_chan(right_chan),
        .mute(mute), .sample_strobe(f_strobe), .sclk(f_sclk), .lrclk(f_lrclk),
        .sdata(f_sdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: value that a latch on this clk would capture
    // ------------------------------------------------------------------------
    logic [15:0] cand_l = '0;
    logic [15:0] cand_r = '0;
    always @(posedge clk) begin
        cand_l <= mute ? 16'h0 : left_chan;
        cand_r <= mute ? 16'h0 : right_chan;
    end

    // ------------------------------------------------------------------------
    // Monitor for the default-clock instance
    // ------------------------------------------------------------------------
    logic [63:0] exp_frame = '0;
    logic [63:0] got = '0;
    int          idx = -1;          // next bit of the current frame, -1 = none
    logic        prev_sclk = 1'b0, prev_sdata = 1'b0, prev_lr = 1'b0;
    int          half_cnt = 0;
    logic        seen_toggle = 1'b0;
    int          falls_since_rel = 0;
    logic        after_rst = 1'b1;
    int          strobe_cnt = 0;
    logic [15:0] last_l = '0, last_r = '0;

    always @(negedge clk) begin
        logic fell, rose;
        if (reset) begin
            check_val("rst_sclk",   sclk, 0);
            check_val("rst_lrclk",  lrclk, 0);
            check_val("rst_sdata",  sdata, 0);
            check_val("rst_strobe", sample_strobe, 0);
            idx             = -1;
            after_rst       = 1'b1;
            falls_since_rel = 0;
            seen_toggle     = 1'b0;
            half_cnt        = 0;
        end else begin
            fell = prev_sclk && !sclk;
            rose = !prev_sclk && sclk;
            if (!fell)
                check_val("stable_off_fall", {sdata, lrclk}, {prev_sdata, prev_lr});
            if (fell) falls_since_rel++;
            half_cnt++;
            if (sclk != prev_sclk) begin
                if (seen_toggle)
                    check_val("half_period_2or3", (half_cnt == 2 || half_cnt == 3), 1);
                seen_toggle = 1'b1;
                half_cnt    = 0;
            end
            if (sample_strobe) begin
                strobe_cnt++;
                check_val("strobe_on_fall", fell, 1);
                if (after_rst) begin
                    check_val("first_fall_latches", falls_since_rel, 1);
                    after_rst = 1'b0;
                end
                if (idx >= 0) check_val("frame_len", idx, 64);
                exp_frame = {cand_l, 16'h0, cand_r, 16'h0};
                got       = '0;
                idx       = 0;
            end
            if (rose && idx >= 0 && idx < 64) begin
                got[63-idx] = sdata;
                check_val("lrclk_slot", lrclk, (idx >= 31 && idx <= 62));
                idx++;
                if (idx == 64) begin
                    check_val("left_word",  got[63:48], exp_frame[63:48]);
                    check_val("left_pad",   got[47:32], 0);
                    check_val("right_word", got[31:16], exp_frame[31:16]);
                    check_val("right_pad",  got[15:0],  0);
                    last_l = got[63:48];
                    last_r = got[31:16];
                end
            end
        end
        prev_sclk  = sclk;
        prev_sdata = sdata;
        prev_lr    = lrclk;
    end

    // ------------------------------------------------------------------------
    // Monitor for the fast instance
    // ------------------------------------------------------------------------
    logic f_started = 1'b0;
    logic f_prev_sclk = 1'b0;
    int   f_clk_cnt = 0;
    int   f_hi = 0;

    always @(negedge clk) begin
        if (reset) begin
            check_val("f_rst_outs", {f_strobe, f_sclk, f_lrclk, f_sdata}, 0);
            f_started = 1'b0;
        end else begin
            if (f_started) check_val("f_sclk_every_clk", f_sclk != f_prev_sclk, 1);
            f_clk_cnt++;
            if (f_lrclk) f_hi++;
            if (f_strobe) begin
                if (f_started) begin
                    check_val("f_strobe_period", f_clk_cnt, 128);
                    check_val("f_lrclk_high", f_hi, 64);
                end
                f_started = 1'b1;
                f_clk_cnt = 0;
                f_hi      = 0;
            end
        end
        f_prev_sclk = f_sclk;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic wait_strobe(input int n);
        for (int k = 0; k < n; k++) begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 2000 && !found; i++) begin
                @(negedge clk);
                if (sample_strobe) found = 1'b1;
            end
            check_val("strobe_seen", found, 1);
        end
    endtask

    task automatic wait_slot(input int s);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (idx >= s) found = 1'b1;
        end
        check_val("slot_reached", found, 1);
    endtask

    initial begin
        int s0;
        reset      = 1'b1;
        left_chan  = '0;
        right_chan = '0;
        mute       = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Fixed pattern decode
        left_chan  = 16'hA5C3;
        right_chan = 16'h0F81;
        wait_strobe(2);
        check_val("t2_left",  last_l, 16'hA5C3);
        check_val("t2_right", last_r, 16'h0F81);

        // Mid-frame input change does not tear the current word
        left_chan = 16'h1234;
        wait_strobe(1);
        wait_slot(6);
        left_chan = 16'hFFFF;
        wait_strobe(1);
        check_val("t4_cur_frame",  last_l, 16'h1234);
        wait_strobe(1);
        check_val("t4_next_frame", last_l, 16'hFFFF);

        // Mute takes effect at the next latch only
        left_chan  = 16'h7FFF;
        right_chan = 16'h7FFF;
        wait_strobe(1);
        mute = 1'b1;
        wait_strobe(1);
        check_val("t5_pre_mute", last_l, 16'h7FFF);
        mute = 1'b0;
        wait_strobe(1);
        check_val("t5_muted_l", last_l, 16'h0);
        check_val("t5_muted_r", last_r, 16'h0);
        wait_strobe(1);
        check_val("t5_unmuted", last_l, 16'h7FFF);

        // Randomised inputs and mute changing at arbitrary times
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) left_chan  = 16'($urandom);
            if ($urandom_range(0, 99) < 3) right_chan = 16'($urandom);
            if ($urandom_range(0, 999) < 5) mute = ~mute;
        end
        mute = 1'b0;

        // Reset in the middle of the right word
        left_chan  = 16'hBEEF;
        right_chan = 16'hCAFE;
        wait_strobe(1);
        wait_slot(41);
        #2 reset = 1'b1;
        #1;
        check_val("rst_async_outs", {sample_strobe, sclk, lrclk, sdata}, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        wait_strobe(2);
        check_val("post_rst_left",  last_l, 16'hBEEF);
        check_val("post_rst_right", last_r, 16'hCAFE);

        // Long-term frame rate at default clocking: 30000 clks ~ 102.86 frames
        s0 = strobe_cnt;
        repeat (30000) @(negedge clk);
        check_val("rate_in_range",
                  ((strobe_cnt - s0) >= 101 && (strobe_cnt - s0) <= 104), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
